// File: rtl/skinny_sched_pkg.sv
// Shared constants and types for the masked Skinny-64 S-box sequencer.
package skinny_sched_pkg;

    localparam int unsigned NIBBLES  = 16;
    localparam int unsigned SBOX_LAT = 2;
    localparam int unsigned NSHARES  = 3;
    localparam int unsigned STATE_W  = 4 * NIBBLES;

    typedef enum logic [1:0] {
        StIdle,
        StFeed,
        StDrain,
        StDone
    } sched_state_e;

    typedef struct packed {
        logic       valid;
        logic [3:0] idx;
    } sched_tag_t;

endpackage

// File: rtl/sched_tag_pipe.sv
// Shift register of nibble tags that mirrors the S-box pipeline latency.
module sched_tag_pipe
    import skinny_sched_pkg::*;
#(
    parameter int unsigned DEPTH = SBOX_LAT
) (
    input  logic       clk,
    input  logic       rst,
    input  sched_tag_t tag_in,
    output sched_tag_t tag_out
);

    sched_tag_t pipe_q [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            pipe_q[0] <= tag_in;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

    assign tag_out = pipe_q[DEPTH-1];

endmodule

// File: rtl/skinny_sbox_sched_d2.sv
// Feeds 16 nibbles of a 3-share state through one shared external S-box and reassembles
// the result. Optional macro SKINNY_SBOX_SCHED_ZEROIZE_EN wipes consumed and stale data.
module skinny_sbox_sched_d2
    import skinny_sched_pkg::*;
#(
    parameter int unsigned FRESH_W = 24
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_i,
    output logic               busy_o,
    output logic               done_o,
    input  logic [STATE_W-1:0] state_s0_i,
    input  logic [STATE_W-1:0] state_s1_i,
    input  logic [STATE_W-1:0] state_s2_i,
    output logic [STATE_W-1:0] state_s0_o,
    output logic [STATE_W-1:0] state_s1_o,
    output logic [STATE_W-1:0] state_s2_o,
    input  logic [FRESH_W-1:0] fresh_i,
    output logic [3:0]         sb_x_s0_o,
    output logic [3:0]         sb_x_s1_o,
    output logic [3:0]         sb_x_s2_o,
    output logic [FRESH_W-1:0] sb_fresh_o,
    input  logic [3:0]         sb_y_s0_i,
    input  logic [3:0]         sb_y_s1_i,
    input  logic [3:0]         sb_y_s2_i
);

    localparam logic [3:0] LAST_IDX  = 4'(NIBBLES - 1);
    localparam logic [3:0] DRAIN_END = 4'(SBOX_LAT - 1);

    sched_state_e state_q, state_d;
    logic [3:0]   idx_q, idx_d;
    sched_tag_t   tag_in, tag_out;

    logic [STATE_W-1:0] inbuf_s0_q, inbuf_s1_q, inbuf_s2_q;
    logic [STATE_W-1:0] res_s0_q, res_s1_q, res_s2_q;

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        busy_o    = 1'b0;
        done_o    = 1'b0;
        tag_in    = '0;
        sb_x_s0_o = 4'b0;
        sb_x_s1_o = 4'b0;
        sb_x_s2_o = 4'b0;
        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    state_d = StFeed;
                    idx_d   = 4'd0;
                end
            end
            StFeed: begin
                busy_o       = 1'b1;
                tag_in.valid = 1'b1;
                tag_in.idx   = idx_q;
                sb_x_s0_o    = inbuf_s0_q[{idx_q, 2'b00} +: 4];
                sb_x_s1_o    = inbuf_s1_q[{idx_q, 2'b00} +: 4];
                sb_x_s2_o    = inbuf_s2_q[{idx_q, 2'b00} +: 4];
                if (idx_q == LAST_IDX) begin
                    state_d = StDrain;
                    idx_d   = 4'd0;
                end else begin
                    idx_d = idx_q + 4'd1;
                end
            end
            // idx doubles as the drain counter
            StDrain: begin
                busy_o = 1'b1;
                if (idx_q == DRAIN_END) begin
                    state_d = StDone;
                    idx_d   = 4'd0;
                end else begin
                    idx_d = idx_q + 4'd1;
                end
            end
            StDone: begin
                done_o  = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            idx_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            inbuf_s0_q <= '0;
            inbuf_s1_q <= '0;
            inbuf_s2_q <= '0;
            res_s0_q   <= '0;
            res_s1_q   <= '0;
            res_s2_q   <= '0;
        end else begin
            if (state_q == StIdle && start_i) begin
                inbuf_s0_q <= state_s0_i;
                inbuf_s1_q <= state_s1_i;
                inbuf_s2_q <= state_s2_i;
            end
`ifdef SKINNY_SBOX_SCHED_ZEROIZE_EN
            if (state_q == StFeed) begin
                inbuf_s0_q[{idx_q, 2'b00} +: 4] <= 4'b0;
                inbuf_s1_q[{idx_q, 2'b00} +: 4] <= 4'b0;
                inbuf_s2_q[{idx_q, 2'b00} +: 4] <= 4'b0;
            end
            if (state_q == StDone) begin
                res_s0_q <= '0;
                res_s1_q <= '0;
                res_s2_q <= '0;
            end
`endif
            if (tag_out.valid) begin
                res_s0_q[{tag_out.idx, 2'b00} +: 4] <= sb_y_s0_i;
                res_s1_q[{tag_out.idx, 2'b00} +: 4] <= sb_y_s1_i;
                res_s2_q[{tag_out.idx, 2'b00} +: 4] <= sb_y_s2_i;
            end
        end
    end

    sched_tag_pipe #(
        .DEPTH (SBOX_LAT)
    ) u_tag_pipe (
        .clk     (clk),
        .rst     (rst),
        .tag_in  (tag_in),
        .tag_out (tag_out)
    );

    assign sb_fresh_o = fresh_i;
    assign state_s0_o = res_s0_q;
    assign state_s1_o = res_s1_q;
    assign state_s2_o = res_s2_q;

endmodule

// File: tb/tb_skinny_sbox_sched_d2.sv
// Randomized bench for skinny_sbox_sched_d2 with a behavioural 2-cycle masked S-box stub.
module tb_skinny_sbox_sched_d2;

    localparam int unsigned FRESH_W = 24;

    logic               clk = 1'b0;
    logic               rst;
    logic               start_i;
    logic               busy_o, done_o;
    logic [63:0]        state_s0_i, state_s1_i, state_s2_i;
    logic [63:0]        state_s0_o, state_s1_o, state_s2_o;
    logic [FRESH_W-1:0] fresh_i;
    logic [3:0]         sb_x_s0_o, sb_x_s1_o, sb_x_s2_o;
    logic [FRESH_W-1:0] sb_fresh_o;
    logic [3:0]         sb_y_s0_i, sb_y_s1_i, sb_y_s2_i;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    skinny_sbox_sched_d2 #(
        .FRESH_W (FRESH_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start_i    (start_i),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .state_s0_i (state_s0_i),
        .state_s1_i (state_s1_i),
        .state_s2_i (state_s2_i),
        .state_s0_o (state_s0_o),
        .state_s1_o (state_s1_o),
        .state_s2_o (state_s2_o),
        .fresh_i    (fresh_i),
        .sb_x_s0_o  (sb_x_s0_o),
        .sb_x_s1_o  (sb_x_s1_o),
        .sb_x_s2_o  (sb_x_s2_o),
        .sb_fresh_o (sb_fresh_o),
        .sb_y_s0_i  (sb_y_s0_i),
        .sb_y_s1_i  (sb_y_s1_i),
        .sb_y_s2_i  (sb_y_s2_i)
    );

    function automatic logic [3:0] sbox4(input logic [3:0] v);
        case (v)
            4'h0: sbox4 = 4'hC;  4'h1: sbox4 = 4'h6;  4'h2: sbox4 = 4'h9;  4'h3: sbox4 = 4'h0;
            4'h4: sbox4 = 4'h1;  4'h5: sbox4 = 4'hA;  4'h6: sbox4 = 4'h2;  4'h7: sbox4 = 4'hB;
            4'h8: sbox4 = 4'h3;  4'h9: sbox4 = 4'h8;  4'hA: sbox4 = 4'h5;  4'hB: sbox4 = 4'hD;
            4'hC: sbox4 = 4'h4;  4'hD: sbox4 = 4'hE;  4'hE: sbox4 = 4'h7;  default: sbox4 = 4'hF;
        endcase
    endfunction

    function automatic logic [63:0] sbox64(input logic [63:0] v);
        logic [63:0] r;
        for (int i = 0; i < 16; i++) r[4*i +: 4] = sbox4(v[4*i +: 4]);
        return r;
    endfunction

    // Stub S-box: recombine, substitute, re-mask with fresh bits; two register stages.
    logic [11:0]        st1_x;
    logic [FRESH_W-1:0] st1_f;
    always @(posedge clk) begin
        st1_x     <= {sb_x_s2_o, sb_x_s1_o, sb_x_s0_o};
        st1_f     <= sb_fresh_o;
        sb_y_s0_i <= sbox4(st1_x[3:0] ^ st1_x[7:4] ^ st1_x[11:8]) ^ st1_f[3:0] ^ st1_f[7:4];
        sb_y_s1_i <= st1_f[3:0];
        sb_y_s2_i <= st1_f[7:4];
    end

    initial begin
        fresh_i = '0;
        forever begin
            @(negedge clk);
            fresh_i = FRESH_W'($urandom);
        end
    end

    logic [63:0] xor_out;
    assign xor_out = state_s0_o ^ state_s1_o ^ state_s2_o;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [63:0] x);
        logic [63:0] m1, m2;
        m1 = {$urandom, $urandom};
        m2 = {$urandom, $urandom};
        state_s1_i = m1;
        state_s2_i = m2;
        state_s0_i = x ^ m1 ^ m2;
    endtask

    // Caller has start_i high for the launching edge; counts cycles until done_o.
    task automatic wait_done(input bit hold, input int pulse_cyc, input int exp_lat,
                             input logic [63:0] x);
        int lat = 0;
        int busy_cnt = 0;
        for (int c = 1; c <= 60; c++) begin
            tick();
            start_i = hold || (c == pulse_cyc);
            if (c == 3) check_eq("fresh_pass", 64'(sb_fresh_o), 64'(fresh_i));
`ifdef SKINNY_SBOX_SCHED_ZEROIZE_EN
            if (c == 10 && exp_lat == 19)
                check_eq("zeroize_buf",
                         64'(dut.inbuf_s0_q[35:0] | dut.inbuf_s1_q[35:0] | dut.inbuf_s2_q[35:0]),
                         64'd0);
`endif
            if (busy_o) busy_cnt++;
            if (done_o) begin
                lat = c;
                break;
            end
        end
        check_eq("done_latency", 64'(lat), 64'(exp_lat));
        check_eq("busy_cycles", 64'(busy_cnt), 64'd18);
        check_eq("result", xor_out, sbox64(x));
    endtask

    task automatic post_done(input logic [63:0] x);
        tick();
        check_eq("done_pulse_width", 64'(done_o), 64'd0);
`ifdef SKINNY_SBOX_SCHED_ZEROIZE_EN
        check_eq("zeroize_res", state_s0_o | state_s1_o | state_s2_o, 64'd0);
`else
        check_eq("result_hold", xor_out, sbox64(x));
`endif
    endtask

    task automatic check_idle_outputs(input string tag);
        check_eq({tag, "_busy"}, 64'(busy_o), 64'd0);
        check_eq({tag, "_done"}, 64'(done_o), 64'd0);
        check_eq({tag, "_s0"}, state_s0_o, 64'd0);
        check_eq({tag, "_s1"}, state_s1_o, 64'd0);
        check_eq({tag, "_s2"}, state_s2_o, 64'd0);
        check_eq({tag, "_sbx"}, 64'({sb_x_s2_o, sb_x_s1_o, sb_x_s0_o}), 64'd0);
    endtask

    initial begin
        logic [63:0] x;
        int dcnt;
        rst        = 1'b1;
        start_i    = 1'b0;
        state_s0_i = '0;
        state_s1_i = '0;
        state_s2_i = '0;
        repeat (3) tick();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check_idle_outputs("reset_idle");
        end

        // Known vector.
        x = 64'h0123456789ABCDEF;
        load(x);
        start_i = 1'b1;
        wait_done(1'b0, 0, 19, x);
        check_eq("known_vector", xor_out, 64'hC6901A2B385D4E7F);
        post_done(x);

        // Random states.
        repeat (6) begin
            x = {$urandom, $urandom};
            load(x);
            start_i = 1'b1;
            wait_done(1'b0, 0, 19, x);
            post_done(x);
        end

        // Back-to-back with start held high.
        load(64'h0);
        start_i = 1'b1;
        wait_done(1'b1, 0, 19, 64'h0);
        check_eq("b2b_zero", xor_out, 64'hCCCCCCCCCCCCCCCC);
        load(64'hFFFFFFFFFFFFFFFF);
        wait_done(1'b1, 0, 20, 64'hFFFFFFFFFFFFFFFF);
        check_eq("b2b_ones", xor_out, 64'hFFFFFFFFFFFFFFFF);
        start_i = 1'b0;
        post_done(64'hFFFFFFFFFFFFFFFF);

        // Start pulse while busy is ignored.
        x = {$urandom, $urandom};
        load(x);
        start_i = 1'b1;
        wait_done(1'b0, 7, 19, x);
        dcnt = 0;
        for (int i = 0; i < 25; i++) begin
            tick();
            if (done_o) dcnt++;
        end
        check_eq("extra_done", 64'(dcnt), 64'd0);
`ifndef SKINNY_SBOX_SCHED_ZEROIZE_EN
        check_eq("busy_start_result", xor_out, sbox64(x));
`endif

        // Reset mid-FEED.
        load({$urandom, $urandom});
        start_i = 1'b1;
        for (int c = 1; c <= 9; c++) begin
            tick();
            start_i = 1'b0;
        end
        rst = 1'b1;
        tick();
        check_idle_outputs("mid_reset");
        rst = 1'b0;
        tick();
        x = 64'h0123456789ABCDEF;
        load(x);
        start_i = 1'b1;
        wait_done(1'b0, 0, 19, x);
        post_done(x);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/skinny_sbox_sched_d2.md
Name: skinny_sbox_sched_d2

Overview:
- Sequencer that shares one second-order masked Skinny-64 S-box instance across all 16 nibbles of a 3-share masked 64-bit state.
- Latches the state on `start_i`, issues one nibble per cycle into the 2-stage S-box pipeline and forwards fresh randomness every cycle.
- Tracks in-flight nibbles with an index tag pipe, reassembles the 3-share substituted state and signals completion.
- Sits between the round-function controller and the external S-box instance; the S-box itself is not instantiated here.

Parameters:
- NIBBLES, 16, nibbles per state; state width = 4*NIBBLES.
- SBOX_LAT, 2, S-box input-to-output latency in cycles. Must match the connected S-box.
- FRESH_W, 24, fresh random bits per S-box evaluation per cycle.

Ports:
- clk  in  1  clock
- rst  in  1  reset. Synchronous, active-high.
- start_i  in  1  start request. Sampled only in IDLE.
- busy_o  out  1  operation in progress
- done_o  out  1  one-cycle completion pulse; `state_s*_o` are valid in this cycle
- state_s0_i, state_s1_i, state_s2_i  in  64 each  input state shares
- state_s0_o, state_s1_o, state_s2_o  out  64 each  substituted state shares
- fresh_i  in  FRESH_W  fresh randomness. Must be new every cycle while `busy_o`=1; no backpressure.
- sb_x_s0_o, sb_x_s1_o, sb_x_s2_o  out  4 each  S-box input shares
- sb_fresh_o  out  FRESH_W  S-box Fresh input
- sb_y_s0_i, sb_y_s1_i, sb_y_s2_i  in  4 each  S-box output shares

Behaviour:
- Reset values:
  - FSM goes to IDLE.
  - `busy_o`=0, `done_o`=0, `state_s*_o`=0.
  - Input buffer = 0, nibble index = 0, tag pipe all invalid.
  - `sb_x_s*_o`=0.
- FSM states: IDLE, FEED, DRAIN, DONE.
- IDLE -> FEED when `start_i`=1. In that same edge the three input shares are latched into the buffer and the index is cleared.
- FEED:
  - In each cycle k=0..NIBBLES-1, drive `sb_x_s*_o` = buffer nibble k, i.e. bits [4k+3:4k] of each share.
  - Push tag {valid=1, idx=k} into the tag pipe (SBOX_LAT deep).
  - After k=NIBBLES-1, go to DRAIN.
- DRAIN: lasts SBOX_LAT cycles. Push invalid tags, drive `sb_x_s*_o`=0. Then go to DONE.
- DONE: lasts 1 cycle. `done_o`=1, `busy_o`=0. Then go to IDLE.
- Result capture: every cycle the pipe-output tag is valid, write `sb_y_s*_i` into result nibble tag.idx of each share. `state_s*_o` is the result register and holds its value until the next DONE overwrites it.
- `sb_fresh_o` = `fresh_i` combinationally in all states.
- `busy_o`=1 in FEED and DRAIN only.
- Timing, with `start_i` sampled at edge 0:
  - nibble k issued in cycle k+1;
  - its result appears in cycle k+1+SBOX_LAT;
  - `done_o` in cycle NIBBLES+SBOX_LAT+1 (= 19 for the defaults).
  - Fresh is consumed in cycles 1..18.
- `start_i` while not in IDLE is ignored; it is not queued. `start_i` held high re-triggers in the cycle after DONE, since IDLE samples it.
- `rst` mid-operation: abort immediately, apply all reset values, and discard in-flight S-box data; the S-box's internal registers need no reset. The first `start_i` after reset behaves normally.
- The shares are never combined: no logic XORs different shares of the same nibble.

Optional Feature:
- Macro `SKINNY_SBOX_SCHED_ZEROIZE_EN`.
- When defined:
  - each buffer nibble is cleared to 0 in all three shares in the cycle after it is issued;
  - the result register is cleared at the edge that leaves DONE, so `state_s*_o` is valid only while `done_o`=1 and is 0 otherwise.
- When undefined: the buffer keeps its contents and the result register holds until overwritten.

Decomposition:
- Package `skinny_sched_pkg` holds:
  - constants NIBBLES, SBOX_LAT, NSHARES=3;
  - FSM state enum typedef;
  - tag struct {valid, idx[3:0]}.
- One sub-module, `sched_tag_pipe`: a SBOX_LAT-deep shift register of tags, with synchronous reset to invalid.

Test Plan:
- Reset-then-idle: hold `rst` 3 cycles, then idle 5 cycles -> `busy_o`=0, `done_o`=0, `state_s*_o`=0, `sb_x_s*_o`=0.
- Functional, with the real S-box connected: unmasked state 0x0123456789ABCDEF split with random s1/s2 -> XOR of output shares = 0xC6901A2B385D4E7F; `done_o` exactly 19 cycles after `start_i`; `busy_o` high in cycles 1–18.
- Back-to-back with `start_i` held high: inputs 0x0000000000000000 then 0xFFFFFFFFFFFFFFFF -> recombined outputs 0xCCCCCCCCCCCCCCCC, then 0xFFFFFFFFFFFFFFFF; second `done_o` 20 cycles after the first.
- Start while busy: pulse `start_i` in cycle 7 -> ignored; exactly one `done_o`; result unchanged.
- Reset mid-FEED: assert `rst` in cycle 9 -> next cycle `busy_o`=0 and `state_s*_o`=0. A subsequent start with 0x0123456789ABCDEF yields the correct result with no stale nibbles.
- With `SKINNY_SBOX_SCHED_ZEROIZE_EN`: in cycle 10, buffer nibbles 0..8 are 0 in all shares; `state_s*_o`=0 one cycle after `done_o`.
